// File: rtl/seq_approx_divider.sv
// Restoring-style unsigned divider (2N/N -> N quotient, N remainder), one quotient bit per cycle, MSB first.
// Latency: N+1 cycles from the start-sampling edge to the done cycle; busy covers the N RUN cycles.
// Backpressure: none; start is only accepted in IDLE, so requests during RUN/DONE are dropped.
module seq_approx_divider #(
  parameter int N           = 8,
  parameter int APPROX_ROWS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           approx_en,
  input  logic [2*N-1:0] n,
  input  logic [N-1:0]   d,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  nlo_q;     // low half of the dividend, consumed one bit per iteration
  logic [N-1:0]  d_q;
  logic          apx_q;
  logic [N-1:0]  rem_q;     // partial remainder R
  logic [KW-1:0] k_q;       // current quotient bit index
  logic [N-1:0]  quot_q;
  logic [N-1:0]  r_q;
  logic          busy_q;
  logic          done_q;
  logic          dz_q;
  logic          ov_q;

  logic [N:0]    w;
  logic          top;
  logic [N-1:0]  low;
  logic [N-1:0]  diff;
  logic          use_apx;
  logic          b;
  logic          qbit;
  logic [N-1:0]  rem_d;

  // One iteration: shift in the next dividend bit, trial-subtract d through a ripple chain, restore on borrow
  always_comb begin
    w       = {rem_q, nlo_q[k_q]};
    top     = w[N];
    low     = w[N-1:0];
    use_apx = apx_q && (int'(k_q) < APPROX_ROWS);
    diff    = '0;
    b       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (use_apx && low[i] && d_q[i] && !b) begin
        // approximate cell deviates only for x=1, y=1, bin=0
        diff[i] = 1'b1;
        b       = 1'b1;
      end else begin
        diff[i] = low[i] ^ d_q[i] ^ b;
        b       = (~low[i] & d_q[i]) | (~(low[i] ^ d_q[i]) & b);
      end
    end
    // a set carry-out bit in W means W >= 2^N > d, so the subtraction always fits
    qbit  = top | ~b;
    rem_d = qbit ? diff : low;
  end

  // Control FSM with registered outputs; reset wins over everything, including start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nlo_q   <= '0;
      d_q     <= '0;
      apx_q   <= 1'b0;
      rem_q   <= '0;
      k_q     <= '0;
      quot_q  <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            nlo_q   <= n[N-1:0];
            d_q     <= d;
            apx_q   <= approx_en;
            rem_q   <= n[2*N-1:N];
            k_q     <= KW'(N - 1);
            quot_q  <= '0;
            r_q     <= '0;
            dz_q    <= (d == '0);
            ov_q    <= (n[2*N-1:N] >= d);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          quot_q[k_q] <= qbit;
          rem_q       <= rem_d;
          k_q         <= k_q - KW'(1);
          if (k_q == '0) begin
            r_q     <= rem_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = quot_q;
  assign r           = r_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed-vector bench for seq_approx_divider, plus protocol corner cases and a short random sweep.
// A second instance with APPROX_ROWS=0 runs in lockstep and must always behave exactly.
// Expected values are hand-computed constants, plain arithmetic, or a bit-level cell model.
module tb_seq_approx_divider;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        approx_en = 1'b0;
  logic [15:0] n = '0;
  logic [7:0]  d = '0;

  logic        busy, done, div_by_zero, overflow;
  logic [7:0]  q, r;
  logic        busy0, done0, dz0, ov0;
  logic [7:0]  q0, r0;

  int total = 0;
  int bad   = 0;

  seq_approx_divider #(.N(N), .APPROX_ROWS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .approx_en(approx_en), .n(n), .d(d),
    .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  seq_approx_divider #(.N(N), .APPROX_ROWS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .approx_en(approx_en), .n(n), .d(d),
    .busy(busy0), .done(done0), .q(q0), .r(r0), .div_by_zero(dz0), .overflow(ov0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-level reference: restoring division using the exact / approximate one-bit subtractor cells
  function automatic logic [15:0] model(input logic [15:0] nn, input logic [7:0] dd,
                                        input bit ap, input int rows);
    logic [7:0] rem, low, dif, qv;
    logic       top, bb, x, y, qb;
    rem = nn[15:8];
    qv  = '0;
    dif = '0;
    for (int k = 7; k >= 0; k--) begin
      top = rem[7];
      low = {rem[6:0], nn[k]};
      bb  = 1'b0;
      for (int i = 0; i < 8; i++) begin
        x = low[i];
        y = dd[i];
        if (ap && (k < rows) && x && y && !bb) begin
          dif[i] = 1'b1;
          bb     = 1'b1;
        end else begin
          dif[i] = x ^ y ^ bb;
          bb     = (~x & y) | (~(x ^ y) & bb);
        end
      end
      qb    = top | ~bb;
      qv[k] = qb;
      rem   = qb ? dif : low;
    end
    return {qv, rem};
  endfunction

  // Issue one division and wait for done; returns in the done cycle (1 time unit after the edge)
  task automatic do_op(input logic [15:0] nn, input logic [7:0] dd, input bit ap,
                       input bit disturb, output int lat, output int bcnt);
    @(negedge clk);
    n = nn; d = dd; approx_en = ap; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (disturb) begin
      n = 16'h0050; d = 8'd3; approx_en = ~ap;
    end
    lat  = 0;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) bcnt++;
      start = disturb && (c == 3);
      @(posedge clk); #1;
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    bit          apx;
    logic [7:0]  q;
    logic [7:0]  r;
    bit          dz;
    bit          ov;
  } vec_t;

  vec_t vt[9];

  initial begin
    int lat, bcnt, seen;
    logic [15:0] rn;
    logic [7:0]  rd;
    logic [15:0] m;

    vt[0] = '{16'd1000,  8'd7,   1'b0, 8'd142,  8'd6,    1'b0, 1'b0};
    vt[1] = '{16'd100,   8'd10,  1'b1, 8'd7,    8'd10,   1'b0, 1'b0};
    vt[2] = '{16'd100,   8'd10,  1'b0, 8'd10,   8'd0,    1'b0, 1'b0};
    vt[3] = '{16'h1234,  8'd0,   1'b0, 8'hFF,   8'h34,   1'b1, 1'b1};
    vt[4] = '{16'h0A00,  8'd5,   1'b0, 8'hFF,   8'd5,    1'b0, 1'b1};
    vt[5] = '{16'h00FF,  8'd1,   1'b0, 8'd255,  8'd0,    1'b0, 1'b0};
    vt[6] = '{16'h7FFF,  8'h80,  1'b0, 8'hFF,   8'h7F,   1'b0, 1'b0};
    vt[7] = '{16'hFEFF,  8'hFF,  1'b0, 8'd255,  8'd254,  1'b0, 1'b0};
    vt[8] = '{16'd0,     8'd3,   1'b0, 8'd0,    8'd0,    1'b0, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst q", q, 0);
    chk("rst r", r, 0);
    chk("rst dz", div_by_zero, 0);
    chk("rst ov", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed vectors
    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].n, vt[i].d, vt[i].apx, 1'b0, lat, bcnt);
      chk($sformatf("v%0d latency", i), lat, N + 1);
      chk($sformatf("v%0d busy cycles", i), bcnt, N);
      chk($sformatf("v%0d q", i), q, vt[i].q);
      chk($sformatf("v%0d r", i), r, vt[i].r);
      chk($sformatf("v%0d dz", i), div_by_zero, vt[i].dz);
      chk($sformatf("v%0d ov", i), overflow, vt[i].ov);
      chk($sformatf("v%0d busy in done", i), busy, 0);
      chk($sformatf("v%0d rows0 done", i), done0, 1);
      chk($sformatf("v%0d rows0 dz", i), dz0, vt[i].dz);
      chk($sformatf("v%0d rows0 ov", i), ov0, vt[i].ov);
      if (vt[i].n[15:8] < vt[i].d) begin
        chk($sformatf("v%0d rows0 q", i), q0, 32'(vt[i].n / {8'd0, vt[i].d}));
        chk($sformatf("v%0d rows0 r", i), r0, 32'(vt[i].n % {8'd0, vt[i].d}));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d done pulse", i), done, 0);
      chk($sformatf("v%0d q hold", i), q, vt[i].q);
      chk($sformatf("v%0d r hold", i), r, vt[i].r);
    end

    // start during DONE is ignored
    do_op(16'd100, 8'd10, 1'b0, 1'b0, lat, bcnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done-start busy", busy, 0);
    chk("done-start done", done, 0);
    @(posedge clk); #1;
    chk("done-start idle", busy, 0);
    chk("done-start q", q, 10);

    // start and input changes during RUN are ignored
    do_op(16'd1000, 8'd7, 1'b0, 1'b1, lat, bcnt);
    chk("run-start latency", lat, N + 1);
    chk("run-start q", q, 142);
    chk("run-start r", r, 6);
    @(posedge clk); #1;
    chk("run-start idle", busy, 0);

    // reset in RUN cycle 4 aborts without done
    @(negedge clk);
    n = 16'h1234; d = 8'd0; approx_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort busy before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort q", q, 0);
    chk("abort r", r, 0);
    chk("abort dz", div_by_zero, 0);
    chk("abort ov", overflow, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort no done", seen, 0);
    do_op(16'd1000, 8'd7, 1'b0, 1'b0, lat, bcnt);
    chk("after abort latency", lat, N + 1);
    chk("after abort q", q, 142);
    chk("after abort r", r, 6);
    @(posedge clk); #1;

    // reset has priority over start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; n = 16'd100; d = 8'd10;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst prio busy", busy, 0);
    @(posedge clk); #1;
    chk("rst prio stays idle", busy, 0);

    // random exact sweep against arithmetic
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom_range(1, 255));
      rn = {8'($urandom_range(0, int'(rd) - 1)), 8'($urandom)};
      do_op(rn, rd, 1'b0, 1'b0, lat, bcnt);
      chk($sformatf("rx%0d latency", i), lat, N + 1);
      chk($sformatf("rx%0d q n=%h d=%h", i, rn, rd), q, 32'(rn / {8'd0, rd}));
      chk($sformatf("rx%0d r n=%h d=%h", i, rn, rd), r, 32'(rn % {8'd0, rd}));
      @(posedge clk); #1;
    end

    // random approximate sweep against the cell model; rows=0 instance must stay exact
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom_range(0, 255));
      rn = 16'($urandom);
      if (i < 10) rn[15:8] = 8'($urandom_range(0, 255)) % (rd == 0 ? 8'd1 : rd);
      m = model(rn, rd, 1'b1, 4);
      do_op(rn, rd, 1'b1, 1'b0, lat, bcnt);
      chk($sformatf("ra%0d latency", i), lat, N + 1);
      chk($sformatf("ra%0d q n=%h d=%h", i, rn, rd), q, m[15:8]);
      chk($sformatf("ra%0d r n=%h d=%h", i, rn, rd), r, m[7:0]);
      if (rn[15:8] < rd) begin
        chk($sformatf("ra%0d rows0 q", i), q0, 32'(rn / {8'd0, rd}));
        chk($sformatf("ra%0d rows0 r", i), r0, 32'(rn % {8'd0, rd}));
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_approx_divider.md
SEQ_APPROX_DIVIDER -- requirements
Module: seq_approx_divider

Interface
REQ-001 SHALL have parameter N, default 8: divisor, quotient and remainder width; dividend is 2N bits.
REQ-002 SHALL have parameter APPROX_ROWS, default 4, legal range 0..N: number of final iterations (quotient bits APPROX_ROWS-1..0) that may use the approximate cell.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-006 SHALL have port approx_en, input, 1: 1 = approximate cells in the last APPROX_ROWS iterations; 0 = exact cells throughout; sampled with start.
REQ-007 SHALL have port n, input, 2N: dividend; sampled with start.
REQ-008 SHALL have port d, input, N: divisor; sampled with start.
REQ-009 SHALL have port busy, output, 1: high while iterating.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when q/r become valid.
REQ-011 SHALL have port q, output, N: quotient.
REQ-012 SHALL have port r, output, N: remainder.
REQ-013 SHALL have port div_by_zero, output, 1: the sampled d was 0.
REQ-014 SHALL have port overflow, output, 1: the sampled n[2N-1:N] >= d, i.e. quotient does not fit in N bits.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after exactly N iterations; DONE->IDLE after one cycle.
REQ-016 SHALL, on start in IDLE, capture n, d and approx_en; load partial remainder R = n[2N-1:N]; set iteration index k = N-1; clear q, r, div_by_zero and overflow.
REQ-017 SHALL, in each RUN cycle, form W = {R, n[k]} (N+1 bits); top = W[N]; low = W[N-1:0].
REQ-018 SHALL, in the same cycle, subtract d from low through an LSB-first ripple chain of N one-bit subtractor cells with borrow-in 0.
REQ-019 SHALL set quotient bit q[k] = top | ~borrow_out.
REQ-020 SHALL set next R = q[k] ? diff : low; k decrements; one quotient bit per cycle, MSB first.
REQ-021 SHALL use the exact cell: diff = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
REQ-022 SHALL use the approximate cell, which equals the exact cell except at x=1, y=1, bin=0, where diff=1 and bout=1.
REQ-023 SHALL use the approximate cell in all N columns when approx_en=1 and k < APPROX_ROWS; all other iterations use the exact cell.
REQ-024 SHALL, with approx_en=0 and no overflow, produce the exact unsigned result: n = q*d + r with r < d.
REQ-025 SHALL, in DONE, drive r = final R and assert done for that cycle only; q, r and the flags hold until the next accepted start.
REQ-026 SHALL give a latency of N+1 cycles from the start-sampling edge to the done cycle; busy is high exactly during the N RUN cycles.
REQ-027 SHALL, for d=0, assert div_by_zero and let the datapath run unmodified, yielding q = all ones and r = n[N-1:0].
REQ-028 SHALL compute overflow at start; it is flag only and does not alter the datapath.
REQ-029 SHALL ignore start while in RUN or DONE; a new start is accepted the cycle after DONE (back-to-back throughput: one division per N+2 cycles).
REQ-030 SHALL ignore input changes on n, d and approx_en after capture.

Reset
REQ-031 SHALL, on rst high at a clock edge, go to IDLE and clear busy, done, q, r, div_by_zero, overflow, R and k, regardless of state.
REQ-032 SHALL, on rst during RUN, abort the operation with no done pulse; rst has priority over start in the same cycle.

Verification
REQ-033 SHALL cover exact division: N=8, approx_en=0, n=1000, d=7 -> done 9 cycles after start; q=142, r=6, overflow=0.
REQ-034 SHALL cover approximate division: approx_en=1, APPROX_ROWS=4, n=100, d=10 -> q=7, r=10; the same inputs with approx_en=0 -> q=10, r=0.
REQ-035 SHALL cover divide by zero: n=0x1234, d=0 -> div_by_zero=1, q=0xFF, r=0x34.
REQ-036 SHALL cover overflow: n=0x0A00, d=5 -> overflow=1, done still pulses after 9 cycles.
REQ-037 SHALL cover protocol: start pulsed again during RUN -> ignored, result of the first operation unchanged; rst asserted in cycle 4 of RUN -> outputs all 0, no done, next start accepted normally.
REQ-038 SHALL cover a random sweep: approx_en=0 with n[15:8] < d matches the arithmetic reference; approx_en=1 matches a bit-accurate cell model; APPROX_ROWS=0 with approx_en=1 equals exact.
